// File: rtl/onn_phase_loader.sv
// Purpose : serial-to-parallel loader of an oscillator phase frame for the ONN, MSB of each word first.
// Latency : phi_out/frame_valid update on the edge that captures the last frame bit (parity bit if enabled).
// Backpr. : one frame buffered; load=1 while a frame awaits onn_ack drops the bit and sets sticky overrun.
//
// Ports:
//   clk         single clock, rising edge
//   re          synchronous active-low reset
//   bit_in      serial phase data, sampled only when load=1
//   load        qualifies bit_in
//   onn_ack     downstream accepts the presented frame (only honoured while holding a frame)
//   phi_out     [0:N_OSC*PHASE_W-1] phase vector, osc i at [i*PHASE_W +: PHASE_W], MSB at lower index
//   frame_valid phi_out holds a complete, unconsumed frame
//   busy        frame shift in progress
//   overrun     sticky: bit offered while a frame awaited acknowledgement
//   par_err     one-cycle pulse on parity failure (always 0 without ONN_LOADER_PARITY_EN)
//
// Build option: define ONN_LOADER_PARITY_EN to append an even-parity bit to every frame.
module onn_phase_loader #(
    parameter int PHASE_W = 4,
    parameter int N_OSC   = 15
) (
    input  logic                         clk,
    input  logic                         re,
    input  logic                         bit_in,
    input  logic                         load,
    input  logic                         onn_ack,
    output logic [0:N_OSC*PHASE_W-1]     phi_out,
    output logic                         frame_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         par_err
);

    localparam int FRAME_W = N_OSC * PHASE_W;
    localparam int CW      = $clog2(FRAME_W + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_W - 1);

`ifdef ONN_LOADER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [0:FRAME_W-1]  sr;
    logic [0:FRAME_W-1]  sr_nxt;

    // Shift register with the current bit already placed at position cnt, so the
    // completing edge can publish the full frame without an extra cycle.
    always_comb begin
        sr_nxt = sr;
        if (cnt <= LAST_IDX) begin
            sr_nxt[cnt] = bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!re) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            phi_out     <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            par_err     <= 1'b0;
        end else begin
            par_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        sr    <= sr_nxt;
                        cnt   <= cnt + 1'b1;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                // load=0 here is a pause: counter and data simply hold.
                SHIFT: begin
                    if (load) begin
                        sr <= sr_nxt;
                        if (cnt == LAST_IDX) begin
`ifdef ONN_LOADER_PARITY_EN
                            cnt   <= cnt + 1'b1;
                            state <= PARITY;
`else
                            phi_out     <= sr_nxt;
                            frame_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= HOLD;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

`ifdef ONN_LOADER_PARITY_EN
                // Even parity over data plus parity bit; a bad frame never reaches phi_out.
                PARITY: begin
                    if (load) begin
                        busy <= 1'b0;
                        if ((^sr ^ bit_in) == 1'b0) begin
                            phi_out     <= sr;
                            frame_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            par_err <= 1'b1;
                            cnt     <= '0;
                            state   <= IDLE;
                        end
                    end
                end
`endif

                // Bits offered here are dropped, including on the ack edge itself.
                HOLD: begin
                    if (load) begin
                        overrun <= 1'b1;
                    end
                    if (onn_ack) begin
                        frame_valid <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onn_phase_loader.sv
// Purpose : self-checking bench for onn_phase_loader; frames are scoreboarded and compared on frame_valid rise.
// Latency : expects frame_valid visible right after the edge capturing the last bit (or parity bit).
// Backpr. : exercises pause (load=0), hold with overrun, ack, and mid-frame reset.
module tb_onn_phase_loader;

    localparam int PW = 4;
    localparam int NO = 15;
    localparam int FW = PW * NO;

    logic            clk = 1'b0;
    logic            re = 1'b0;
    logic            bit_in = 1'b0;
    logic            load = 1'b0;
    logic            onn_ack = 1'b0;
    logic [0:FW-1]   phi_out;
    logic            frame_valid;
    logic            busy;
    logic            overrun;
    logic            par_err;

    int              checks = 0;
    int              errors = 0;
    logic [0:FW-1]   exp_q[$];
    logic            fv_d = 1'b0;

    onn_phase_loader #(.PHASE_W(PW), .N_OSC(NO)) dut (
        .clk         (clk),
        .re          (re),
        .bit_in      (bit_in),
        .load        (load),
        .onn_ack     (onn_ack),
        .phi_out     (phi_out),
        .frame_valid (frame_valid),
        .busy        (busy),
        .overrun     (overrun),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rising frame_valid must match the oldest expected frame.
    always @(negedge clk) begin
        if (frame_valid && !fv_d) begin
            if (exp_q.size() == 0) check("sb_unexpected_frame", 64'd1, 64'd0);
            else                   check("sb_phi", phi_out, exp_q.pop_front());
        end
        fv_d = frame_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        load   = 1'b1;
        bit_in = b;
        tick();
        load   = 1'b0;
    endtask

    task automatic send_frame(input logic [0:FW-1] f, input int pause_at, input int pause_len, input string tag);
        int busy_lo  = 0;
        int fv_early = 0;
        exp_q.push_back(f);
        for (int k = 0; k < FW; k++) begin
            send_bit(f[k]);
            if (k < FW - 1) begin
                if (!busy)       busy_lo++;
                if (frame_valid) fv_early++;
            end
            if (k == pause_at) begin
                for (int p = 0; p < pause_len; p++) begin
                    tick();
                    if (!busy)       busy_lo++;
                    if (frame_valid) fv_early++;
                end
            end
        end
`ifdef ONN_LOADER_PARITY_EN
        if (!busy) busy_lo++;
        if (frame_valid) fv_early++;
        send_bit(^f);
`endif
        check({tag, "_busy_gap"}, busy_lo, 0);
        check({tag, "_fv_early"}, fv_early, 0);
        check({tag, "_fv"}, frame_valid, 1);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    task automatic ack();
        onn_ack = 1'b1;
        tick();
        onn_ack = 1'b0;
        check("ack_fv_low", frame_valid, 0);
    endtask

    initial begin
        logic [3:0]    w[NO];
        logic [0:FW-1] fa;
        logic [0:FW-1] fb;
        logic [0:FW-1] ones;
        int            fv_lo;

        w = '{4'b1000, 4'b0000, 4'b1000, 4'b1100, 4'b0001, 4'b0000, 4'b0000, 4'b0001,
              4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1000, 4'b1000};
        for (int i = 0; i < NO; i++) fa[i*PW +: PW] = w[i];
        for (int k = 0; k < FW; k++) fb[k] = 1'($urandom_range(0, 1));
        ones = '1;

        // Reset state
        re = 1'b0;
        repeat (3) tick();
        check("rst_phi", phi_out, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", par_err, 0);
        re = 1'b1;
        tick();

        // Reference frame, contiguous load
        send_frame(fa, -1, 0, "A");
        check("A_w0", phi_out[0:3], 4'b1000);
        check("A_w3", phi_out[12:15], 4'b1100);
        check("A_w14", phi_out[56:59], 4'b1000);

        // Hold for 10 cycles, then load pulses -> overrun, frame untouched
        fv_lo = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!frame_valid) fv_lo++;
        end
        check("hold_fv", fv_lo, 0);
        check("hold_ovr0", overrun, 0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("hold_ovr1", overrun, 1);
        check("hold_phi", phi_out, fa);
        check("hold_fv2", frame_valid, 1);

        // Ack together with load: bit dropped, no new frame started
        load   = 1'b1;
        bit_in = 1'b1;
        ack();
        load   = 1'b0;
        check("ackld_busy", busy, 0);
        check("ackld_phi", phi_out, fa);
        tick();
        check("ackld_busy2", busy, 0);

        // Random frame with onn_ack held high during shifting (must be ignored)
        onn_ack = 1'b1;
        send_frame(fb, -1, 0, "B");
        onn_ack = 1'b0;
        tick();
        check("B_fv_hold", frame_valid, 1);
        check("B_phi", phi_out, fb);
        ack();

        // Same reference frame with a 5-cycle pause after bit 20
        send_frame(fa, 20, 5, "P");
        check("P_phi", phi_out, fa);
        check("P_ovr_sticky", overrun, 1);
        ack();

        // Reset one cycle after bit 30 discards the partial frame
        for (int k = 0; k <= 30; k++) send_bit(fa[k]);
        re = 1'b0;
        tick();
        re = 1'b1;
        check("mrst_phi", phi_out, 0);
        check("mrst_fv", frame_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ovr", overrun, 0);
        check("mrst_perr", par_err, 0);
        fv_lo = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frame_valid) fv_lo++;
        end
        check("mrst_no_fv", fv_lo, 0);

        // Fresh all-ones frame
        send_frame(ones, -1, 0, "ONES");
        check("ONES_phi", phi_out, ones);
        ack();

`ifdef ONN_LOADER_PARITY_EN
        // Bad parity: pulse, no frame, phi_out keeps the all-ones frame
        for (int k = 0; k < FW; k++) send_bit(fa[k]);
        send_bit(~(^fa));
        check("perr_pulse", par_err, 1);
        check("perr_fv", frame_valid, 0);
        check("perr_phi", phi_out, ones);
        tick();
        check("perr_clear", par_err, 0);
        check("perr_busy", busy, 0);
`else
        check("noparity_perr", par_err, 0);
`endif

        tick();
        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
